// File: rtl/lab02_truth_table_checker_if.sv
// Stimulus/response bundle between the truth-table checker and whoever hosts it.
// The checker owns the slave view; the board or bench owns the master view.
interface lab02_truth_table_checker_if;
  logic        start;
  logic        f;
  logic        w;
  logic        x;
  logic        y;
  logic        z;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] obs_table;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;

  modport master (
    output start, f,
    input  w, x, y, z, busy, done, pass, obs_table, mismatch_cnt, first_fail
  );

  modport slave (
    input  start, f,
    output w, x, y, z, busy, done, pass, obs_table, mismatch_cnt, first_fail
  );
endinterface

// File: rtl/lab02_truth_table_checker.sv
// Sweeps all 16 {w,x,y,z} vectors, samples f on the last dwell cycle of each,
// and compares the observed truth table against EXPECTED.
module lab02_truth_table_checker #(
  parameter int          DWELL    = 4,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input logic clk,
  input logic rst,
  lab02_truth_table_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  idx;
  logic [7:0]  cnt;
  logic [3:0]  vec;
  logic [15:0] obs;
  logic [4:0]  mcnt;
  logic [3:0]  ffail;
  logic        launch;
  logic        sample;
  logic        mismatch;

  assign launch   = (state != S_DRIVE) && bus.start;
  assign sample   = (state == S_DRIVE) && (cnt == LAST);
  assign mismatch = (bus.f != EXPECTED[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.start) next_state = S_DRIVE;
      S_DRIVE: if (sample && idx == 4'd15) next_state = S_DONE;
      S_DONE:  if (bus.start) next_state = S_DRIVE;
      default: next_state = S_IDLE;
    endcase
  end

  // The stimulus register is loaded with the next index on the sample edge so
  // the new vector appears on the same edge that idx advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 4'd0;
      cnt   <= 8'd0;
      vec   <= 4'd0;
      obs   <= 16'd0;
      mcnt  <= 5'd0;
      ffail <= 4'd0;
    end else if (launch) begin
      idx   <= 4'd0;
      cnt   <= 8'd0;
      vec   <= 4'd0;
      obs   <= 16'd0;
      mcnt  <= 5'd0;
      ffail <= 4'd0;
    end else if (sample) begin
      obs[idx] <= bus.f;
      if (mismatch) begin
        mcnt <= mcnt + 5'd1;
        if (mcnt == 5'd0) begin
          ffail <= idx;
        end
      end
      if (idx == 4'd15) begin
        vec <= 4'd0;
      end else begin
        idx <= idx + 4'd1;
        cnt <= 8'd0;
        vec <= idx + 4'd1;
      end
    end else if (state == S_DRIVE) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    bus.busy         = (state == S_DRIVE);
    bus.done         = (state == S_DONE);
    bus.pass         = (state == S_DONE) && (mcnt == 5'd0);
    bus.w            = vec[3];
    bus.x            = vec[2];
    bus.y            = vec[1];
    bus.z            = vec[0];
    bus.obs_table    = obs;
    bus.mismatch_cnt = mcnt;
    bus.first_fail   = ffail;
  end

endmodule

// File: tb/tb_lab02_truth_table_checker.sv
// Directed bench: three checker instances with different DWELL/EXPECTED, a
// scoreboard of expected sweep results, and per-cycle stimulus checks.
module tb_lab02_truth_table_checker;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  mc;
    logic [3:0]  ff;
    logic        ps;
  } exp_t;

  logic clk;
  logic rst;
  logic fix_b;
  int   total;
  int   bad;
  exp_t sb[$];

  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        pass_v  [3];
  logic [3:0]  vec_v   [3];
  logic [15:0] tbl_v   [3];
  logic [4:0]  mc_v    [3];
  logic [3:0]  ff_v    [3];

  lab02_truth_table_checker_if bus_a ();
  lab02_truth_table_checker_if bus_b ();
  lab02_truth_table_checker_if bus_c ();

  lab02_truth_table_checker #(.DWELL(4), .EXPECTED(16'h6996)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  lab02_truth_table_checker #(.DWELL(4), .EXPECTED(16'h8001)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  lab02_truth_table_checker #(.DWELL(2), .EXPECTED(16'h0100)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
  );

  // Units under test: parity for A, a fixable stuck-at-0 for B, stuck-at-0 for C.
  assign bus_a.f = bus_a.w ^ bus_a.x ^ bus_a.y ^ bus_a.z;
  assign bus_b.f = fix_b & ((bus_b.w & bus_b.x & bus_b.y & bus_b.z) |
                            ~(bus_b.w | bus_b.x | bus_b.y | bus_b.z));
  assign bus_c.f = 1'b0;

  assign bus_a.start = start_v[0];
  assign bus_b.start = start_v[1];
  assign bus_c.start = start_v[2];

  assign busy_v[0] = bus_a.busy;
  assign busy_v[1] = bus_b.busy;
  assign busy_v[2] = bus_c.busy;
  assign done_v[0] = bus_a.done;
  assign done_v[1] = bus_b.done;
  assign done_v[2] = bus_c.done;
  assign pass_v[0] = bus_a.pass;
  assign pass_v[1] = bus_b.pass;
  assign pass_v[2] = bus_c.pass;
  assign vec_v[0]  = {bus_a.w, bus_a.x, bus_a.y, bus_a.z};
  assign vec_v[1]  = {bus_b.w, bus_b.x, bus_b.y, bus_b.z};
  assign vec_v[2]  = {bus_c.w, bus_c.x, bus_c.y, bus_c.z};
  assign tbl_v[0]  = bus_a.obs_table;
  assign tbl_v[1]  = bus_b.obs_table;
  assign tbl_v[2]  = bus_c.obs_table;
  assign mc_v[0]   = bus_a.mismatch_cnt;
  assign mc_v[1]   = bus_b.mismatch_cnt;
  assign mc_v[2]   = bus_c.mismatch_cnt;
  assign ff_v[0]   = bus_a.first_fail;
  assign ff_v[1]   = bus_b.first_fail;
  assign ff_v[2]   = bus_c.first_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int k);
    check_output("rst_busy",  32'(busy_v[k]), 32'd0);
    check_output("rst_done",  32'(done_v[k]), 32'd0);
    check_output("rst_pass",  32'(pass_v[k]), 32'd0);
    check_output("rst_vec",   32'(vec_v[k]),  32'd0);
    check_output("rst_table", 32'(tbl_v[k]),  32'd0);
    check_output("rst_mcnt",  32'(mc_v[k]),   32'd0);
    check_output("rst_ffail", 32'(ff_v[k]),   32'd0);
  endtask

  // One full sweep on instance k; optionally pokes start while busy.
  task automatic apply_stimulus(input int k, input int dwell, input logic [15:0] tbl,
                                input logic [4:0] mc, input logic [3:0] ff, input bit poke);
    exp_t e;
    exp_t got;
    int   elapsed;
    int   busy_cycles;
    int   budget;
    e.tbl = tbl;
    e.mc  = mc;
    e.ff  = ff;
    e.ps  = (mc == 5'd0);
    sb.push_back(e);
    budget = 16 * dwell + 10;
    @(negedge clk);
    start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    check_output("start_done_drop", 32'(done_v[k]), 32'd0);
    check_output("start_pass_drop", 32'(pass_v[k]), 32'd0);
    check_output("start_tbl_clr",   32'(tbl_v[k]),  32'd0);
    check_output("start_mc_clr",    32'(mc_v[k]),   32'd0);
    check_output("start_busy",      32'(busy_v[k]), 32'd1);
    elapsed     = 0;
    busy_cycles = 0;
    while (!done_v[k] && elapsed <= budget) begin
      if (busy_v[k]) begin
        busy_cycles++;
        check_output("vector", 32'(vec_v[k]), 32'(elapsed / dwell));
      end
      @(posedge clk);
      elapsed++;
      @(negedge clk);
      start_v[k] = poke && (elapsed % 3 == 0) && (elapsed < 16 * dwell - 2);
    end
    start_v[k] = 1'b0;
    got = sb.pop_front();
    check_output("done_reached", 32'(done_v[k]), 32'd1);
    check_output("done_latency", 32'(elapsed), 32'(16 * dwell));
    check_output("busy_cycles",  32'(busy_cycles), 32'(16 * dwell));
    check_output("done_busy",    32'(busy_v[k]), 32'd0);
    check_output("done_vec",     32'(vec_v[k]), 32'd0);
    check_output("table",        32'(tbl_v[k]), 32'(got.tbl));
    check_output("mismatch_cnt", 32'(mc_v[k]), 32'(got.mc));
    check_output("pass",         32'(pass_v[k]), 32'(got.ps));
    if (!got.ps) begin
      check_output("first_fail", 32'(ff_v[k]), 32'(got.ff));
    end
  endtask

  initial begin
    int guard;
    total      = 0;
    bad        = 0;
    fix_b      = 1'b0;
    rst        = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    start_v[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) check_reset(k);

    $display("[TB] full pass, parity unit, DWELL=4");
    apply_stimulus(0, 4, 16'h6996, 5'd0, 4'd0, 1'b0);

    $display("[TB] injected failures, EXPECTED=8001 and 0100");
    apply_stimulus(1, 4, 16'h0000, 5'd2, 4'd0, 1'b0);
    apply_stimulus(2, 2, 16'h0000, 5'd1, 4'd8, 1'b0);

    $display("[TB] restart from DONE after fixing the unit");
    fix_b = 1'b1;
    apply_stimulus(1, 4, 16'h8001, 5'd0, 4'd0, 1'b0);

    $display("[TB] start pulses while busy");
    apply_stimulus(0, 4, 16'h6996, 5'd0, 4'd0, 1'b1);

    $display("[TB] reset mid-sweep at vector 7");
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    guard = 0;
    while (vec_v[0] != 4'd7 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_output("reached_vec7", 32'(vec_v[0]), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset(0);
    repeat (3) @(negedge clk);
    check_output("idle_after_rst", 32'({busy_v[0], done_v[0]}), 32'd0);
    apply_stimulus(0, 4, 16'h6996, 5'd0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
